// File: rtl/prog_mem_loader.sv
// prog_mem_loader: instruction memory with one-cycle read plus length-prefixed byte-stream program loader
module prog_mem_loader #(
  parameter int ADDR_W = 10,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  output logic [31:0] instruction,
  output logic        running,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        load_busy,
  output logic        load_err
);
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, RUN} state_t;
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;
  state_t state;
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] wptr, nlast;
  logic [1:0] lane;
  logic [7:0] nlo;
  logic [23:0] asm_w;
  logic [15:0] hdr;
  logic we;
  logic unused_pc;
  assign unused_pc = ^{pc[15:ADDR_W+2], pc[1:0]};
  assign hdr = {ld_data, nlo};
  assign we = state == DATA && ld_valid && !ld_start && lane == 2'd3;
  // Image words land in the array on the edge that samples their fourth byte
  always_ff @(posedge clk)
    if (we) mem[wptr] <= {ld_data, asm_w};
  // Fetch read register: real words only while running, otherwise a NOP
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) instruction <= NOP_WORD;
    else instruction <= running ? mem[pc[ADDR_W+1:2]] : NOP_WORD;
  // Loader FSM; a start pulse restarts from any state and beats a same-cycle byte
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      running <= 1'b0;
      load_busy <= 1'b0;
      load_err <= 1'b0;
      wptr <= '0;
      nlast <= '0;
      lane <= '0;
      nlo <= '0;
      asm_w <= '0;
    end else if (ld_start) begin
      state <= HDR0;
      running <= 1'b0;
      load_busy <= 1'b1;
      load_err <= 1'b0;
      wptr <= '0;
      lane <= '0;
    end else if (ld_valid) begin
      case (state)
        HDR0: begin
          nlo <= ld_data;
          state <= HDR1;
        end
        HDR1: begin
          wptr <= '0;
          lane <= '0;
          nlast <= ADDR_W'(hdr - 16'd1);
          if (hdr == 16'd0) begin
            state <= RUN;
            running <= 1'b1;
            load_busy <= 1'b0;
          end else if ({1'b0, hdr} > DEPTH) begin
            state <= IDLE;
            load_err <= 1'b1;
            load_busy <= 1'b0;
          end else state <= DATA;
        end
        DATA: begin
          lane <= lane + 2'd1;
          asm_w <= {lane == 2'd2 ? ld_data : asm_w[23:16],
                    lane == 2'd1 ? ld_data : asm_w[15:8],
                    lane == 2'd0 ? ld_data : asm_w[7:0]};
          if (lane == 2'd3) begin
            wptr <= wptr + 1'b1;
            if (wptr == nlast) begin
              state <= RUN;
              running <= 1'b1;
              load_busy <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: scoreboard-driven checks of loader FSM and fetch read path
module tb_prog_mem_loader;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, rst_n = 0, ld_start = 0, ld_valid = 0;
  logic [15:0] pc = 0;
  logic [7:0] ld_data = 0;
  logic [31:0] instruction;
  logic running, load_busy, load_err;
  int checks = 0, errors = 0;
  logic [31:0] model [0:1023];
  logic [31:0] exp_q [$];
  logic [31:0] e;

  always #5 clk = ~clk;

  prog_mem_loader dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instruction(instruction), .running(running),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .load_busy(load_busy), .load_err(load_err)
  );

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat ($urandom_range(0, gap)) @(negedge clk);
    ld_valid = 1; ld_data = b;
    @(negedge clk);
    ld_valid = 0;
  endtask

  task automatic send_hdr(input logic [15:0] n, input int gap);
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic pulse_start();
    ld_start = 1;
    @(negedge clk);
    ld_start = 0;
  endtask

  task automatic drive_pc(input logic [15:0] a, input logic run);
    pc = a;
    exp_q.push_back(run ? model[a[11:2]] : NOP);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({instruction, running, load_busy, load_err} !== {NOP, 3'b000}) begin
      errors++; $display("FAIL reset: got %h/%b%b%b want %h/000", instruction, running, load_busy, load_err, NOP);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_load();
    pulse_start();
    checks++;
    if ({running, load_busy, load_err} !== 3'b010) begin
      errors++; $display("FAIL busy_rise: got %b want 010", {running, load_busy, load_err});
    end
    send_hdr(16'd2, 0);
    send_word(32'h0010_0513, 0); model[0] = 32'h0010_0513;
    send_word(32'h0020_0593, 0); model[1] = 32'h0020_0593;
    checks++;
    if ({running, load_busy} !== 2'b10) begin
      errors++; $display("FAIL run_after_load: got %b want 10", {running, load_busy});
    end
    checks++;
    if (instruction !== NOP) begin
      errors++; $display("FAIL first_nop: got %h want %h", instruction, NOP);
    end
    drive_pc(16'h0004, 1);
    e = exp_q.pop_front(); checks++;
    if (instruction !== e) begin errors++; $display("FAIL read_pc4: got %h want %h", instruction, e); end
    drive_pc(16'h0000, 1);
    e = exp_q.pop_front(); checks++;
    if (instruction !== e) begin errors++; $display("FAIL read_pc0: got %h want %h", instruction, e); end
  endtask

  task automatic test_oversize();
    pulse_start();
    send_hdr(16'h0401, 1);
    checks++;
    if ({running, load_busy, load_err} !== 3'b001) begin
      errors++; $display("FAIL oversize_err: got %b want 001", {running, load_busy, load_err});
    end
    drive_pc(16'h0000, 0);
    e = exp_q.pop_front(); checks++;
    if (instruction !== e) begin errors++; $display("FAIL oversize_nop: got %h want %h", instruction, e); end
    pulse_start();
    checks++;
    if ({running, load_busy, load_err} !== 3'b010) begin
      errors++; $display("FAIL err_clear: got %b want 010", {running, load_busy, load_err});
    end
  endtask

  task automatic test_restart();
    send_hdr(16'd1, 2);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    ld_start = 1; ld_valid = 1; ld_data = 8'h99;
    @(negedge clk);
    ld_start = 0; ld_valid = 0;
    checks++;
    if ({running, load_busy} !== 2'b01) begin
      errors++; $display("FAIL restart_busy: got %b want 01", {running, load_busy});
    end
    send_hdr(16'd1, 0);
    send_word(32'hDEAD_BEEF, 2); model[0] = 32'hDEAD_BEEF;
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL restart_run: got %b want 1", running); end
    drive_pc(16'h0000, 1);
    drive_pc(16'h0004, 1);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front(); checks++;
      if (instruction !== e && i == 1) begin errors++; $display("FAIL restart_keep: got %h want %h", instruction, e); end
    end
    drive_pc(16'h0000, 1);
    e = exp_q.pop_front(); checks++;
    if (instruction !== e) begin errors++; $display("FAIL restart_word: got %h want %h", instruction, e); end
  endtask

  task automatic test_wrap();
    logic [15:0] addrs [4] = '{16'h0007, 16'h1004, 16'h1000, 16'h0005};
    pulse_start();
    send_hdr(16'd2, 1);
    send_word(32'h1234_5678, 1); model[0] = 32'h1234_5678;
    send_word(32'hAABB_CCDD, 1); model[1] = 32'hAABB_CCDD;
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL wrap_run: got %b want 1", running); end
    @(negedge clk);
    foreach (addrs[i]) begin
      drive_pc(addrs[i], 1);
      e = exp_q.pop_front(); checks++;
      if (instruction !== e) begin errors++; $display("FAIL wrap_read pc=%h: got %h want %h", addrs[i], instruction, e); end
    end
  endtask

  task automatic test_run_restart();
    pc = 16'h0000;
    @(negedge clk);
    pulse_start();
    checks++;
    if ({running, load_busy, instruction} !== {2'b01, model[0]}) begin
      errors++; $display("FAIL run_restart: got %b%b/%h want 01/%h", running, load_busy, instruction, model[0]);
    end
    @(negedge clk);
    checks++;
    if (instruction !== NOP) begin errors++; $display("FAIL run_restart_nop: got %h want %h", instruction, NOP); end
  endtask

  task automatic test_reset_midload();
    send_hdr(16'd2, 0);
    send_word(32'hCAFE_F00D, 0); model[0] = 32'hCAFE_F00D;
    send_byte(8'h77, 0);
    #1 rst_n = 0;
    #1 checks++;
    if ({instruction, running, load_busy, load_err} !== {NOP, 3'b000}) begin
      errors++; $display("FAIL async_reset_load: got %h/%b%b%b want %h/000", instruction, running, load_busy, load_err, NOP);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    pulse_start();
    send_hdr(16'd0, 0);
    checks++;
    if ({running, load_busy, load_err} !== 3'b100) begin
      errors++; $display("FAIL zero_len_run: got %b want 100", {running, load_busy, load_err});
    end
    drive_pc(16'h0000, 1);
    drive_pc(16'h0000, 1);
    e = exp_q.pop_front();
    e = exp_q.pop_front(); checks++;
    if (instruction !== e) begin errors++; $display("FAIL retain_w0: got %h want %h", instruction, e); end
    drive_pc(16'h0004, 1);
    e = exp_q.pop_front(); checks++;
    if (instruction !== e) begin errors++; $display("FAIL retain_w1: got %h want %h", instruction, e); end
    #1 rst_n = 0;
    #1 checks++;
    if ({instruction, running} !== {NOP, 1'b0}) begin
      errors++; $display("FAIL async_reset_run: got %h/%b want %h/0", instruction, running, NOP);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load();
    test_oversize();
    test_restart();
    test_wrap();
    test_run_restart();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_mem_loader.md
# prog_mem_loader

Instruction-memory responder for the fetch unit, plus a byte-stream program loader. It serves 32-bit instruction words with one-cycle synchronous read latency against the 16-bit byte-address `pc` issued by the fetch unit. It also owns the `running` flag that gates the fetch unit. While not running, it accepts a length-prefixed little-endian program image from a byte source (e.g. a UART receiver), writes it into the word array, and then asserts `running`.

## Interface
- `ADDR_W`, 10, word-address width; memory depth = 2^ADDR_W words (default 1024 words = 4 KiB)
- `NOP_WORD`, 32'h0000_0013, word driven on `instruction` while not running (addi x0,x0,0)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `pc`  in  16  fetch byte address from fetch unit
- `instruction`  out  32  registered instruction word for the `pc` of the previous cycle
- `running`  out  1  program-run flag to the fetch unit
- `ld_start`  in  1  single-cycle pulse; begin (or restart) a program load
- `ld_valid`  in  1  single-cycle strobe; `ld_data` holds one image byte
- `ld_data`  in  8  image byte
- `load_busy`  out  1  high in states HDR0, HDR1, DATA
- `load_err`  out  1  sticky; set on oversize image, cleared by next `ld_start`

## Operation
- States: IDLE, HDR0, HDR1, DATA, RUN. Reset → IDLE.
- IDLE: `running`=0. `ld_start` → HDR0.
- HDR0: the next `ld_valid` byte is N[7:0] → HDR1.
- HDR1: the next `ld_valid` byte is N[15:8], where N = word count.
  - If N==0 → RUN.
  - If N > 2^ADDR_W → set `load_err`, go to IDLE.
  - Otherwise → DATA, with write pointer `wptr`=0 and byte lane=0.
- DATA: each `ld_valid` byte fills lane 0..3 of the assembly register, little-endian (first byte = bits[7:0]).
  - On the lane-3 byte, write the assembled word to `mem[wptr]` at that same edge, then increment `wptr` and reset the lane to 0.
  - When the written word is number N−1, go to RUN.
- RUN: `running`=1. `ld_start` → HDR0, with `running`=0 from the next cycle.
- `ld_start` in any state, including a load in progress:
  - Go to HDR0.
  - Clear `load_err`, `wptr` and the lane.
  - If `ld_valid` is high in the same cycle, `ld_start` wins and the byte is dropped.
- `ld_valid` in IDLE or RUN is ignored.
- Read path:
  - While `running`=1: `instruction` <= `mem[pc[ADDR_W+1:2]]` every cycle.
  - Otherwise: `instruction` <= `NOP_WORD`.
  - `pc[1:0]` is ignored. `pc` bits above ADDR_W+1 are ignored, so addresses wrap modulo the memory size.
- The memory array has no reset and contents survive `rst_n`. Words at index ≥ N keep their old contents.
- Write and read never collide: writes occur only when `running`=0.

## Timing
- Reset values:
  - `instruction`=`NOP_WORD`
  - `running`=0
  - `load_busy`=0
  - `load_err`=0
  - state IDLE, `wptr`=0, lane=0
- Read latency is 1 cycle. The `pc` presented at edge k gives `mem` data on `instruction` after edge k+1. This matches the fetch unit's `pc_now` register.
- `load_busy` rises the cycle after `ld_start` is sampled.
- `running` rises the cycle after the edge that samples the final data byte, or the second header byte when N==0.
- Bytes may arrive back-to-back (one per cycle) or with arbitrary gaps. There is no back-pressure.
- Reset asserted mid-load: the block goes to IDLE immediately and asynchronously. A partial word is discarded. Words already written remain.
- The first `instruction` after `running` rises is the NOP, because the read register loaded `NOP_WORD` on the previous edge. Real data appears from the second cycle.

## Test plan
- Reset, then load with N=2 and bytes 02 00 | 13 05 10 00 | 93 05 20 00:
  - `mem[0]`=0x00100513 and `mem[1]`=0x00200593.
  - `running`=1 one cycle after the last byte.
  - `pc`=0x0004 → `instruction`=0x00200593 on the next cycle.
- Load with N=0x0401 at ADDR_W=10:
  - `load_err`=1, state IDLE, `running` stays 0, no memory writes.
  - A following `ld_start` clears `load_err`.
- Restart mid-word: during DATA after 2 bytes, pulse `ld_start` together with `ld_valid`. The byte is dropped and the header is re-parsed. A full N=1 image then loads to `mem[0]` correctly.
- Read wrap and alignment: after loading `mem[1]`=0xAABBCCDD:
  - `pc`=0x0007 → 0xAABBCCDD.
  - `pc`=0x1004 at ADDR_W=10 → 0xAABBCCDD.
- In RUN, pulse `ld_start`:
  - `running`=0 and `load_busy`=1 the next cycle.
  - `instruction`=0x00000013 the cycle after.
- Assert `rst_n` low after 5 data bytes:
  - All outputs return to reset values asynchronously.
  - `mem[0]` retains its loaded word, readable after a subsequent N=0 load reaches RUN.
